// File: rtl/cla_pkg.sv
// cla_pkg: shared types and constants for the carry-lookahead subtractor datapath.
package cla_pkg;

    localparam int CLA_SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cla_sub_state_t;

endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder in generate/propagate form.
module cla4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g, p;
    logic       c1, c2, c3;

    assign g  = x & y;
    assign p  = x ^ y;
    // Every carry is flattened so no carry ripples through a previous one.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s  = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_sub_seq.sv
// cla_sub_seq: multi-cycle a - b - borrow_in, one 4-bit CLA slice per clock.
// Define CLA_SUB_OVF_EN to add the signed-overflow output ovf.
module cla_sub_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef CLA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CLA_SLICE_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    cla_sub_state_t   state_q, state_d;
    logic [CW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, nb_q, nb_d, diff_q, diff_d;
    logic             carry_q, carry_d, bout_q, bout_d;
    logic [CW+1:0]    base;
    logic [3:0]       s;
    logic             co, last;
`ifdef CLA_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign base = {k_q, 2'b00};
    assign last = k_q == CW'(N - 1);

    // Subtraction runs as a + ~b + ~borrow_in through the adder slice.
    cla4_slice u_slice (
        .x  (a_q[base +: CLA_SLICE_W]),
        .y  (nb_q[base +: CLA_SLICE_W]),
        .ci (carry_q),
        .s  (s),
        .co (co)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        nb_d    = nb_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        bout_d  = bout_q;
`ifdef CLA_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                a_d     = a;
                nb_d    = ~b;
                carry_d = ~borrow_in;
                k_d     = '0;
            end
            RUN: begin
                diff_d[base +: CLA_SLICE_W] = s;
                carry_d = co;
                k_d     = last ? k_q : k_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    bout_d  = ~co;
`ifdef CLA_SUB_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (a_q[WIDTH-1] ^ s[3]);
`endif
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            nb_q    <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
`ifdef CLA_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
`ifdef CLA_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign diff       = diff_q;
    assign borrow_out = bout_q;
`ifdef CLA_SUB_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_cla_sub_seq.sv
// tb_cla_sub_seq: directed and random operand pairs checked against an arithmetic model.
module tb_cla_sub_seq;

    localparam int W = 16;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b0, borrow_in = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, borrow_out;
    logic [W-1:0] diff;
`ifdef CLA_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0, failures = 0;

    cla_sub_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef CLA_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transaction; hold = cycles of backpressure, pre = out_ready already high.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                         input int hold, input bit pre);
        int           n = 0, lat = 0, sr;
        logic [31:0]  r;
        logic [W-1:0] ed;
        logic         eb, eo;
        r  = {16'b0, x} - {16'b0, y} - {31'b0, bin};
        ed = r[W-1:0];
        eb = int'(x) < int'(y) + int'(bin);
        sr = int'($signed(x)) - int'($signed(y)) - int'(bin);
        eo = (sr > 32767) || (sr < -32768);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 50), 1);
        a = x; b = y; borrow_in = bin; in_valid = 1'b1; out_ready = pre;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check("latency", lat, 4);
        check("diff", diff, ed);
        check("borrow_out", borrow_out, eb);
`ifdef CLA_SUB_OVF_EN
        check("ovf", ovf, eo);
`endif
        check("in_ready_done", in_ready, 0);
        if (!pre) begin
            in_valid = 1'b1;
            repeat (hold) begin
                a = W'($urandom); b = W'($urandom);
                @(negedge clk);
                check("hold_diff", diff, ed);
                check("hold_valid", out_valid, 1);
                check("hold_in_ready", in_ready, 0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("released_valid", out_valid, 0);
        check("released_in_ready", in_ready, 1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
`ifdef CLA_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h0005, 16'h0002, 1'b1, 0, 1'b0);
        do_op(16'hABCD, 16'h1357, 1'b1, 10, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 0, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        // Abort in the middle of RUN, then confirm the block recovers cleanly.
        a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_in_ready", in_ready, 1);
        check("midrun_out_valid", out_valid, 0);
        check("midrun_diff", diff, 0);
        check("midrun_borrow", borrow_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b0);
        for (int i = 0; i < 40; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b0);
        do_op(16'h0000, 16'hFFFF, 1'b1, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_sub_seq.md
# cla_sub_seq

Multi-cycle wide subtractor that computes `a - b - borrow_in` over `WIDTH` bits, four bits per clock, using a single 4-bit carry-lookahead slice. It sits downstream of operand producers on the arithmetic datapath and is the subtract counterpart to the team's 4-bit CLA adder. It trades latency for area, and uses a valid/ready handshake on both the input and the output side.

## Interface
Parameters:
- `WIDTH`, 16, operand and result width. Must be a multiple of 4 and ≥ 4. The slice count is `N = WIDTH/4`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `borrow_in` input 1: incoming borrow.
- `out_valid` output 1: result held and valid.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: result, `a - b - borrow_in` mod 2^WIDTH.
- `borrow_out` output 1: set when `a < b + borrow_in` (unsigned).
- `ovf` output 1: signed overflow. Present only with `CLA_SUB_OVF_EN`.

## Operation
- Implements the identity `a - b - bin = a + ~b + ~bin`.
  - Slice carry-in for slice 0 is `~borrow_in`.
  - For each later slice, carry-in is the previous slice's carry-out.
  - `borrow_out = ~carry_out` of the final slice.
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid` at an edge, latch `a`, `~b` and `~borrow_in`, clear the slice counter, and go to RUN.
  - RUN: each edge processes slice `k` (bits `4k+3:4k`), writes its 4 sum bits into `diff[4k+3:4k]`, registers the carry, and increments `k`. The edge that processes `k = N-1` also sets `borrow_out` and goes to DONE.
  - DONE: `out_valid=1`. `diff` and `borrow_out` are stable. On `out_ready` at an edge, go to IDLE.
- `in_ready` is high only in IDLE. There is no overlap between results; a new operand is accepted only after the previous result is consumed.
- Inputs are sampled only on the accepting edge. Changes to `a`, `b` or `borrow_in` during RUN or DONE have no effect.
- `in_valid` in RUN or DONE is ignored. The producer holds its operands until `in_ready` is high.
- Slice counter width is `$clog2(N)` with a minimum of 1 bit. There is no wrap-around: the counter is reset on each acceptance.
- When `WIDTH=4`, RUN lasts exactly one edge.

## Timing
- Reset values: `in_ready=1` (IDLE), `out_valid=0`, `diff=0`, `borrow_out=0`, `ovf=0`. Internal carry and counter are 0.
- Latency: `out_valid` rises after exactly N rising edges following the accepting edge. The accepting edge is edge 0; DONE is entered at edge N.
- Throughput: at best one result per N+2 cycles (accept, N RUN cycles, output handshake).
- Backpressure: with `out_ready=0`, the block holds in DONE indefinitely with the result unchanged.
- If `out_ready` is already high when DONE is entered, the handshake completes on the next edge and the block returns to IDLE. `in_ready` rises one cycle later.
- Reset asserted in any state, including mid-RUN, returns immediately (asynchronously) to IDLE with all outputs at their reset values. The partial result is discarded.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `CLA_SUB_OVF_EN`:
  - Defined: the `ovf` port exists. It is set on the final RUN edge to `a[W-1] ^ b[W-1]` AND `a[W-1] ^ diff[W-1]`, using the latched operands. It is held in DONE and cleared on reset.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `cla_pkg`:
  - State enumeration `cla_sub_state_t` (IDLE, RUN, DONE).
  - Constant `CLA_SLICE_W = 4`.
- Sub-module `cla4_slice`: purely combinational 4-bit carry-lookahead adder.
  - Inputs: `x[3:0]`, `y[3:0]`, `ci`. Outputs: `s[3:0]`, `co`.
  - Generate/propagate form, `c(i+1) = g(i) | p(i)&c(i)`, with all carries expanded.
  - Instantiated exactly once.
- Top-level `cla_sub_seq` holds the FSM, operand shift/select logic, slice counter and result registers.

## Test plan
- `WIDTH=16`, `a=0x1234`, `b=0x0234`, `borrow_in=0` -> `diff=0x1000`, `borrow_out=0`; `out_valid` exactly 4 edges after acceptance.
- `a=0x0000`, `b=0x0001`, `borrow_in=0` -> `diff=0xFFFF`, `borrow_out=1`.
- `a=0x0005`, `b=0x0002`, `borrow_in=1` -> `diff=0x0002`, `borrow_out=0`.
- `out_ready` held low 10 cycles after `out_valid` -> `diff` stable, `in_ready=0`, a new `in_valid` is ignored; result is released on the first `out_ready` edge, and `in_ready` returns the following cycle.
- `rst` pulsed during RUN slice 2 -> outputs at reset values immediately; the next operand pair `0x00FF - 0x000F` yields `0x00F0`, `borrow_out=0`.
- With `CLA_SUB_OVF_EN`: `0x8000 - 0x0001` -> `diff=0x7FFF`, `ovf=1`, `borrow_out=0`; `0x7FFF - 0x0001` -> `ovf=0`.
